adder_bist_ctrl: RTL and testbench
==================================

Name: adder_bist_ctrl

Overview:
- Built-in self-test controller for the 2-bit ripple-carry adder (RCadder).
- Drives all 32 input combinations of {X2,X1,Y2,Y1,Cin} into the adder and samples its {Cout,S2,S1} response after a settle window.
- Compares each response against a golden sum and reports pass/fail, failure count and the first failing vector.
- Sits beside the adder instance and replaces the hand-written exhaustive stimulus in hardware self-test builds.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before the response is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a test run.
- X2  out  1  adder operand X, bit 1.
- X1  out  1  adder operand X, bit 0.
- Y2  out  1  adder operand Y, bit 1.
- Y1  out  1  adder operand Y, bit 0.
- Cin  out  1  adder carry-in.
- S2  in  1  adder sum, bit 1.
- S1  in  1  adder sum, bit 0.
- Cout  in  1  adder carry-out.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  valid when done=1; 1 means zero mismatches.
- fail_count  out  6  number of mismatching vectors, 0..32.
- first_fail_vec  out  5  index of the lowest failing vector; valid when fail_count != 0.

Behaviour:
- Reset values:
  - state = IDLE; all adder drive outputs 0.
  - busy = 0, done = 0, pass = 0, fail_count = 0, first_fail_vec = 0.
- Vector index vec[4:0] maps to {X2,X1,Y2,Y1,Cin}. Runs count 0..31 in ascending order.
- Expected response {Cout,S2,S1} = {X2,X1} + {Y2,Y1} + Cin, computed as a 3-bit result (no overflow is possible).
- State machine:
  - IDLE: outputs held. If start=1: vec <- 0, clear fail_count / first_fail_vec / pass / done, busy <- 1, settle counter <- 0, go to APPLY.
  - APPLY: drive vec. Increment the settle counter. When it reaches SETTLE_CYCLES-1, go to CHECK.
  - CHECK: sample S2, S1, Cout and compare with expected.
    - On mismatch, increment fail_count. If fail_count was 0, also capture first_fail_vec <- vec.
    - If vec == 31, go to DONE. Otherwise vec <- vec+1, reset the settle counter, go to APPLY.
  - DONE: busy = 0, done = 1, pass = (fail_count == 0). Adder drive outputs return to 0. start=1 restarts exactly as from IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - If start is sampled at edge k, vector 0 is driven from edge k. done rises at edge k + 32*(SETTLE_CYCLES+1); with the default parameter that is 96 cycles.
- start while busy = 1 is ignored; no restart and no effect on counters.
- rst asserted mid-run aborts immediately to the reset values. A partial result is never reported.
- fail_count cannot wrap because its maximum is 32.
- The sampled inputs are treated as combinational responses to the controller's own registered outputs. No synchronisers are required.

Decomposition:
- Shared package adder_bist_pkg:
  - VEC_W = 5, NUM_VECS = 32, RES_W = 3.
  - State encoding constants: IDLE, APPLY, CHECK, DONE.
  - Function expected_sum(vec) returning the 3-bit golden {Cout,S2,S1}.
- One natural sub-module, adder_bist_cmp: combinational golden-model compare of vec against {Cout,S2,S1}, producing a mismatch flag.
- The FSM, counters and result registers stay in adder_bist_ctrl.

Test Plan:
- Correct RCadder attached, SETTLE_CYCLES=2, start pulse -> done=1 exactly 96 cycles later; pass=1, fail_count=0; all 32 vectors observed in ascending order on X2..Cin.
- Adder model with Cout stuck-at-0 -> done=1, pass=0, fail_count=16, first_fail_vec=7 (X2=0, X1=0, Y2=1, Y1=1, Cin=1).
- Adder model with S1 stuck-at-0 -> fail_count=16, first_fail_vec=1.
- Correct adder; second start pulse at cycle 40 of a run -> ignored, done still at cycle 96. Start pulse in DONE -> results clear, new run, done again 96 cycles later.
- rst asserted at cycle 50 of a run with a faulty adder -> next cycle busy=0, done=0, fail_count=0, all drive outputs 0. A later start completes normally.
- SETTLE_CYCLES=1 with a correct adder -> done 64 cycles after start; each vector is held exactly 2 cycles.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types, sizes and golden-sum function for the 2-bit adder self-test.
package adder_bist_pkg;

  localparam int VEC_W    = 5;
  localparam int NUM_VECS = 32;
  localparam int RES_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // vec = {X2,X1,Y2,Y1,Cin}; result = {Cout,S2,S1}
  function automatic logic [RES_W-1:0] expected_sum(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[4:3]} + {1'b0, vec[2:1]} + {2'b00, vec[0]};
  endfunction

endpackage

// File: rtl/adder_bist_cmp.sv
// Golden-model compare of one applied vector against the sampled adder response.
// Purely combinational; no flow control.
module adder_bist_cmp
  import adder_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic [RES_W-1:0] res,
  output logic             mismatch
);

  assign mismatch = (res != expected_sum(vec));

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive self-test sequencer for the 2-bit ripple-carry adder.
// Each vector takes SETTLE_CYCLES+1 cycles; start is ignored while a run is busy.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       X2,
  output logic       X1,
  output logic       Y2,
  output logic       Y1,
  output logic       Cin,
  input  logic       S2,
  input  logic       S1,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_count,
  output logic [4:0] first_fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECS - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec, vec_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [5:0]       fc_nxt;
  logic [4:0]       ff_nxt;
  logic             mismatch;

  adder_bist_cmp u_cmp (
    .vec      (vec),
    .res      ({Cout, S2, S1}),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      cnt            <= cnt_nxt;
      fail_count     <= fc_nxt;
      first_fail_vec <= ff_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    fc_nxt    = fail_count;
    ff_nxt    = first_fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = APPLY;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          fc_nxt    = '0;
          ff_nxt    = '0;
        end
      end
      APPLY: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          fc_nxt = fail_count + 6'd1;
          if (fail_count == 6'd0) begin
            ff_nxt = vec;
          end
        end
        if (vec == LAST_VEC) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          vec_nxt   = vec + 5'd1;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (fail_count == 6'd0);

  // Drive lines rest at zero outside a run so the adder sees a quiet input.
  assign {X2, X1, Y2, Y1, Cin} = busy ? vec : 5'd0;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: fault-injecting adder models, two settle settings.
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  int   mode;
  logic [2:0] fxor [32];
  int checks = 0;
  int failures = 0;

  logic x2_a, x1_a, y2_a, y1_a, cin_a, s2_a, s1_a, cout_a, busy_a, done_a, pass_a;
  logic x2_b, x1_b, y2_b, y1_b, cin_b, s2_b, s1_b, cout_b, busy_b, done_b, pass_b;
  logic [5:0] fc_a, fc_b;
  logic [4:0] ff_a, ff_b;
  logic [4:0] drv_a, drv_b;
  logic start_a, start_b;

  assign drv_a   = {x2_a, x1_a, y2_a, y1_a, cin_a};
  assign drv_b   = {x2_b, x1_b, y2_b, y1_b, cin_b};
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  adder_bist_ctrl #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .X2(x2_a), .X1(x1_a), .Y2(y2_a), .Y1(y1_a), .Cin(cin_a),
    .S2(s2_a), .S1(s1_a), .Cout(cout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .first_fail_vec(ff_a)
  );

  adder_bist_ctrl #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .X2(x2_b), .X1(x1_b), .Y2(y2_b), .Y1(y1_b), .Cin(cin_b),
    .S2(s2_b), .S1(s1_b), .Cout(cout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .first_fail_vec(ff_b)
  );

  // Fault-free sum from plain integer arithmetic.
  function automatic logic [2:0] ideal(input logic [4:0] v);
    int a, b, c;
    a = int'(v[4:3]);
    b = int'(v[2:1]);
    c = int'(v[0]);
    return 3'(a + b + c);
  endfunction

  // Adder under test: 0 good, 1 Cout stuck-at-0, 2 S1 stuck-at-0, 3 per-vector corruption.
  function automatic logic [2:0] adder_resp(input logic [4:0] v, input int md, input logic [2:0] m);
    logic [2:0] r;
    r = ideal(v);
    case (md)
      1:       r[2] = 1'b0;
      2:       r[0] = 1'b0;
      3:       r = r ^ m;
      default: r = r;
    endcase
    return r;
  endfunction

  always_comb {cout_a, s2_a, s1_a} = adder_resp(drv_a, mode, fxor[drv_a]);
  always_comb {cout_b, s2_b, s1_b} = adder_resp(drv_b, mode, fxor[drv_b]);

  logic [4:0] cur_drv, cur_ff;
  logic [5:0] cur_fc;
  logic       cur_busy, cur_done, cur_pass;
  assign cur_drv  = sel ? drv_b  : drv_a;
  assign cur_ff   = sel ? ff_b   : ff_a;
  assign cur_fc   = sel ? fc_b   : fc_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_done = sel ? done_b : done_a;
  assign cur_pass = sel ? pass_b : pass_a;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(output int fc, output int ff);
    fc = 0;
    ff = 0;
    for (int v = 0; v < 32; v++) begin
      if (adder_resp(5'(v), mode, fxor[v]) != ideal(5'(v))) begin
        if (fc == 0) ff = v;
        fc++;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, int'(cur_busy), 0);
    check({tag, "_done"}, int'(cur_done), 0);
    check({tag, "_pass"}, int'(cur_pass), 0);
    check({tag, "_fc"},   int'(cur_fc),   0);
    check({tag, "_ff"},   int'(cur_ff),   0);
    check({tag, "_drv"},  int'(cur_drv),  0);
  endtask

  // One run from a start pulse; optional ignored restart and optional reset abort.
  task automatic run_test(input string tag, input int restart_at, input int abort_at,
                          input int exp_fc, input int exp_ff);
    int spc, c, bad;
    bit got;
    spc = sel ? 2 : 3;
    bad = 0;
    got = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr_done"}, int'(cur_done), 0);
    check({tag, "_clr_fc"},   int'(cur_fc),   0);
    for (c = 0; c < 400; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_vec_seq"}, bad, 0);
        check_quiet({tag, "_abort"});
        return;
      end
      if (cur_done) begin
        got = 1'b1;
        break;
      end
      if (cur_drv != 5'(c / spc) || !cur_busy) bad++;
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_latency"},   c, 32 * spc);
    check({tag, "_vec_seq"},   bad, 0);
    check({tag, "_busy_end"},  int'(cur_busy), 0);
    check({tag, "_drv_end"},   int'(cur_drv), 0);
    check({tag, "_pass"},      int'(cur_pass), (exp_fc == 0) ? 1 : 0);
    check({tag, "_fc"},        int'(cur_fc), exp_fc);
    if (exp_fc != 0) check({tag, "_ff"}, int'(cur_ff), exp_ff);
  endtask

  initial begin
    int efc, eff, rs;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    for (int i = 0; i < 32; i++) fxor[i] = 3'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0; run_test("good",     -1, -1, 0, 0);
    mode = 1; run_test("cout_sa0", -1, -1, 16, 7);
    mode = 2; run_test("s1_sa0",   -1, -1, 16, 1);
    mode = 0; run_test("restart",  40, -1, 0, 0);
    mode = 0; run_test("from_done", -1, -1, 0, 0);
    mode = 1; run_test("abort",    -1, 50, 0, 0);
    repeat (2) @(negedge clk);
    check_quiet("abort_idle");
    mode = 0; run_test("after_abort", -1, -1, 0, 0);

    sel = 1'b1;
    mode = 0; run_test("s1_good", -1, -1, 0, 0);
    mode = 1; run_test("s1_cout", -1, -1, 16, 7);

    mode = 3;
    for (int t = 0; t < 8; t++) begin
      sel = t[0];
      for (int i = 0; i < 32; i++)
        fxor[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      model(efc, eff);
      rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_test($sformatf("rand%0d", t), rs, -1, efc, eff);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
